// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and digit limits for the stopwatch core.
//                state_t    - control state machine encoding
//                *_MAX      - highest legal value of each BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned HUND_MAX = 9;   // hundredths units and tens
    localparam int unsigned SECO_MAX = 9;   // seconds units
    localparam int unsigned SECT_MAX = 5;   // seconds tens
    localparam int unsigned MIN_MAX  = 9;   // minutes

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD counter digit of the stopwatch carry chain.
//                Counts 0..MAX, wrapping to 0 when enabled at MAX.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                en   - advance by one this cycle
//                clr  - synchronous zero (dominates en)
//                q    - registered digit value
//                wrap - combinational: en while q == MAX (carry out)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = HUND_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       wrap
);

    localparam logic [3:0] c_max = 4'(MAX);

    logic [3:0] r_q;
    logic       w_at_max;

    assign w_at_max = (r_q == c_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (en) begin
            r_q <= w_at_max ? 4'd0 : r_q + 4'd1;
        end
    end

    assign q    = r_q;
    assign wrap = en & w_at_max;

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core
//  Description : BCD elapsed-time counter M:SS.HH (max 9:59.99) advanced by a
//                1/100 s strobe and gated by a start/stop/clear state machine.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-high reset
//                tick      - one-cycle 1/100 s strobe
//                strt_stp  - one-cycle start/stop pulse
//                clr       - one-cycle clear pulse (honoured in IDLE/PAUSE)
//                hund_ones, hund_tens, sec_ones, sec_tens, mins - BCD digits
//                running   - state is RUN
//                ovf       - sticky wrap-from-9:59.99 flag
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       strt_stp,
    input  logic       clr,
    output logic [3:0] hund_ones,
    output logic [3:0] hund_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       running,
    output logic       ovf
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_clr_acc;      // clear accepted: only outside RUN
    logic   w_count_en;
    logic   w_wrap_ho;
    logic   w_wrap_ht;
    logic   w_wrap_so;
    logic   w_wrap_st;
    logic   w_wrap_min;     // whole count wraps from 9:59.99
    logic   r_ovf;

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clr outranks strt_stp in IDLE/PAUSE; in RUN clr is ignored so a
    // coincident strt_stp still pauses.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_acc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_clr_acc = 1'b1;
                end else if (strt_stp) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (strt_stp) begin
                    w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (clr) begin
                    w_clr_acc   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (strt_stp) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gated by the registered state, so a tick in the cycle that starts
    // the watch is dropped and one in the cycle that stops it is kept.
    assign w_count_en = tick & (r_state == RUN);

    // ------------------------------------------------------------------
    // Carry chain: each digit's wrap enables the next digit up
    // ------------------------------------------------------------------
    bcd_digit #(.MAX(HUND_MAX)) u_hund_ones (
        .clk (clk), .rst (rst), .en (w_count_en), .clr (w_clr_acc),
        .q   (hund_ones), .wrap (w_wrap_ho)
    );

    bcd_digit #(.MAX(HUND_MAX)) u_hund_tens (
        .clk (clk), .rst (rst), .en (w_wrap_ho), .clr (w_clr_acc),
        .q   (hund_tens), .wrap (w_wrap_ht)
    );

    bcd_digit #(.MAX(SECO_MAX)) u_sec_ones (
        .clk (clk), .rst (rst), .en (w_wrap_ht), .clr (w_clr_acc),
        .q   (sec_ones), .wrap (w_wrap_so)
    );

    bcd_digit #(.MAX(SECT_MAX)) u_sec_tens (
        .clk (clk), .rst (rst), .en (w_wrap_so), .clr (w_clr_acc),
        .q   (sec_tens), .wrap (w_wrap_st)
    );

    bcd_digit #(.MAX(MIN_MAX)) u_mins (
        .clk (clk), .rst (rst), .en (w_wrap_st), .clr (w_clr_acc),
        .q   (mins), .wrap (w_wrap_min)
    );

    // ------------------------------------------------------------------
    // Sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_clr_acc) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_min) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf     = r_ovf;
    assign running = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_core
//  Description : Self-checking bench for stopwatch_core. A reference model
//                keeps elapsed time as a plain centisecond count and derives
//                the BCD digits arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       strt_stp;
    logic       clr;
    logic [3:0] hund_ones;
    logic [3:0] hund_tens;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       running;
    logic       ovf;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = pause
    int m_mode;
    int m_cs;       // elapsed centiseconds, 0..59999
    bit m_ovf;

    stopwatch_core u_dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .strt_stp  (strt_stp),
        .clr       (clr),
        .hund_ones (hund_ones),
        .hund_tens (hund_tens),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .mins      (mins),
        .running   (running),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] dut_vec;
    assign dut_vec = {mins, sec_tens, sec_ones, hund_tens, hund_ones, running, ovf};

    // Build an expected vector from a time value and flags.
    function automatic logic [21:0] mk(input int cs, input bit run, input bit ov);
        int secs;
        secs = (cs / 100) % 60;
        mk = {4'(cs / 6000), 4'(secs / 10), 4'(secs % 10),
              4'((cs % 100) / 10), 4'(cs % 10), run, ov};
    endfunction

    function automatic logic [21:0] model_vec();
        model_vec = mk(m_cs, (m_mode == 1), m_ovf);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cs   = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit c);
        if (m_mode == 1) begin
            if (t) begin
                m_cs = m_cs + 1;
                if (m_cs == 60000) begin
                    m_cs  = 0;
                    m_ovf = 1'b1;
                end
            end
            if (s) m_mode = 2;
        end else if (c) begin
            m_mode = 0;
            m_cs   = 0;
            m_ovf  = 1'b0;
        end else if (s) begin
            m_mode = 1;
        end
    endtask

    // One clock: inputs held across the edge, outputs sampled 1 ns later.
    task automatic cycle(input bit t, input bit s, input bit c);
        tick     = t;
        strt_stp = s;
        clr      = c;
        @(posedge clk);
        model_step(t, s, c);
        #1;
        tick     = 1'b0;
        strt_stp = 1'b0;
        clr      = 1'b0;
    endtask

    // Ticks spaced by an idle cycle, as the prescaler delivers them.
    task automatic spaced_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Back-to-back ticks to reach distant times quickly; the counter has
    // no dependence on tick spacing.
    task automatic fast_ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (dut_vec !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_held got=%h want=%h", dut_vec, 22'd0);
        end
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0);    // tick in IDLE is not counted
        n_total++;
        if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_idle got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_basic();
        cycle(1'b0, 1'b1, 1'b0);
        spaced_ticks(100);
        n_total++;
        if (dut_vec !== mk(100, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL basic_count got=%h want=%h", dut_vec, mk(100, 1'b1, 1'b0));
        end
    endtask

    task automatic test_pause_resume();
        cycle(1'b0, 1'b1, 1'b0);    // pause
        cycle(1'b0, 1'b0, 1'b1);    // clear -> idle
        cycle(1'b0, 1'b1, 1'b0);    // run
        spaced_ticks(37);
        cycle(1'b0, 1'b1, 1'b0);    // pause at 0:00.37
        spaced_ticks(20);
        n_total++;
        if (dut_vec !== mk(37, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL pause_hold got=%h want=%h", dut_vec, mk(37, 1'b0, 1'b0));
        end
        cycle(1'b0, 1'b1, 1'b0);
        spaced_ticks(5);
        n_total++;
        if (dut_vec !== mk(42, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL resume got=%h want=%h", dut_vec, mk(42, 1'b1, 1'b0));
        end
    endtask

    task automatic test_clear_rules();
        spaced_ticks(173);          // 0:02.15
        cycle(1'b0, 1'b0, 1'b1);    // clr ignored in RUN
        n_total++;
        if (dut_vec !== mk(215, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL clr_in_run got=%h want=%h", dut_vec, mk(215, 1'b1, 1'b0));
        end
        cycle(1'b0, 1'b1, 1'b1);    // together in RUN -> pause, count kept
        n_total++;
        if (dut_vec !== mk(215, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL both_in_run got=%h want=%h", dut_vec, mk(215, 1'b0, 1'b0));
        end
        cycle(1'b0, 1'b0, 1'b1);    // clr in PAUSE
        n_total++;
        if (dut_vec !== 22'd0) begin
            n_bad++;
            $display("FAIL clr_in_pause got=%h want=%h", dut_vec, 22'd0);
        end
        cycle(1'b0, 1'b1, 1'b0);
        spaced_ticks(3);
        cycle(1'b0, 1'b1, 1'b0);    // pause at 0:00.03
        cycle(1'b0, 1'b1, 1'b1);    // together in PAUSE -> idle
        cycle(1'b1, 1'b0, 1'b0);    // stays idle, tick ignored
        n_total++;
        if (dut_vec !== 22'd0) begin
            n_bad++;
            $display("FAIL both_in_pause got=%h want=%h", dut_vec, 22'd0);
        end
    endtask

    task automatic test_edge_ticks();
        cycle(1'b1, 1'b1, 1'b0);    // start with coincident tick
        n_total++;
        if (dut_vec !== mk(0, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL tick_at_start got=%h want=%h", dut_vec, mk(0, 1'b1, 1'b0));
        end
        spaced_ticks(2);
        cycle(1'b1, 1'b1, 1'b0);    // stop with coincident tick: counted
        n_total++;
        if (dut_vec !== mk(3, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL tick_at_stop got=%h want=%h", dut_vec, mk(3, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        bit prev_t;
        bit t;
        bit s;
        bit c;
        prev_t = 1'b0;
        for (int i = 0; i < 600; i++) begin
            t = !prev_t && ($urandom_range(0, 1) == 0);
            s = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 11) == 0);
            cycle(t, s, c);
            prev_t = t;
            n_total++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL random step=%0d got=%h want=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_ripple_overflow();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b0);
        fast_ticks(5999);
        n_total++;
        if (dut_vec !== mk(5999, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL at_59_99 got=%h want=%h", dut_vec, mk(5999, 1'b1, 1'b0));
        end
        cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_vec !== mk(6000, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL ripple_1_00 got=%h want=%h", dut_vec, mk(6000, 1'b1, 1'b0));
        end
        fast_ticks(53999);
        n_total++;
        if (dut_vec !== mk(59999, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL at_9_59_99 got=%h want=%h", dut_vec, mk(59999, 1'b1, 1'b0));
        end
        cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_vec !== mk(0, 1'b1, 1'b1)) begin
            n_bad++;
            $display("FAIL overflow_wrap got=%h want=%h", dut_vec, mk(0, 1'b1, 1'b1));
        end
        spaced_ticks(7);
        n_total++;
        if (dut_vec !== mk(7, 1'b1, 1'b1)) begin
            n_bad++;
            $display("FAIL ovf_sticky got=%h want=%h", dut_vec, mk(7, 1'b1, 1'b1));
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        n_total++;
        if (dut_vec !== 22'd0) begin
            n_bad++;
            $display("FAIL ovf_clear got=%h want=%h", dut_vec, 22'd0);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1, 1'b0);
        fast_ticks(20764);          // 3:27.64
        n_total++;
        if (dut_vec !== mk(20764, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL at_3_27_64 got=%h want=%h", dut_vec, mk(20764, 1'b1, 1'b0));
        end
        #2;                         // mid-cycle, away from any edge
        rst = 1'b1;
        #1;
        n_total++;
        if (dut_vec !== 22'd0) begin
            n_bad++;
            $display("FAIL async_reset got=%h want=%h", dut_vec, 22'd0);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0);    // must be idle: tick ignored
        n_total++;
        if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("FAIL after_reset_idle got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        strt_stp = 1'b0;
        clr      = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_pause_resume();
        test_clear_rules();
        test_edge_ticks();
        test_random();
        test_ripple_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
